// File: rtl/puzzle_pkg.sv
// Shared definitions for the puzzle memory block.
//   state_t          : clear-engine states
//   CTRL_*_BIT       : bit positions inside the CTRL register
//   REG_OFF_*        : register offsets relative to the first address past RAM
package puzzle_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // CTRL read view
    localparam int CTRL_BUSY_BIT  = 0;
    localparam int CTRL_DONE_BIT  = 1;
    // CTRL write view
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ACK_BIT   = 1;

    // Register words sit directly above the RAM words
    localparam int REG_OFF_CTRL = 0;
    localparam int REG_OFF_FILL = 1;

endpackage

// File: rtl/puzzle_ram_dp.sv
// True dual-port block RAM with one-cycle registered outputs.
//   clk, rst_n : clock, async active-low reset (output registers only)
//   en_a       : port A enable
//   we_a       : port A byte write enables (all zero = read)
//   addr_a     : port A word address
//   wdata_a    : port A write data
//   q_a        : port A read data, updates only on a port A read
//   addr_b     : port B (read-only) word address
//   q_b        : port B read data, old data on same-cycle port A write
module puzzle_ram_dp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_a,
    input  logic [DATA_W/8-1:0] we_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   wdata_a,
    output logic [DATA_W-1:0]   q_a,
    input  logic [ADDR_W-1:0]   addr_b,
    output logic [DATA_W-1:0]   q_b
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en_a) begin
            for (int i = 0; i < LANES; i++) begin
                if (we_a[i]) begin
                    mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
                end
            end
        end
    end

    // q_a holds its value across writes so the Avalon side can re-use it
    // as the held read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (en_a && (we_a == '0)) begin
                q_a <= mem[addr_a];
            end
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/puzzle_mem.sv
// Puzzle memory: Avalon-MM slave over a dual-port RAM plus CTRL/FILL
// registers and a hardware clear engine; a second read port feeds the display.
//   CLK, RESET            : clock, async active-low reset
//   AVL_*                 : Avalon-MM slave (word addressed, byte enables)
//   DISP_ADDR, DISP_DATA  : display read port, one-cycle latency
module puzzle_mem
    import puzzle_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 13
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_W-1:0]        AVL_ADDR,
    input  logic [DATA_W/8-1:0]      AVL_BYTE_EN,
    input  logic                     AVL_CS,
    input  logic                     AVL_READ,
    input  logic                     AVL_WRITE,
    input  logic [DATA_W-1:0]        AVL_WRITEDATA,
    output logic [DATA_W-1:0]        AVL_READDATA,
    output logic                     AVL_READDATAVALID,
    output logic                     AVL_WAITREQUEST,
    input  logic [$clog2(DEPTH)-1:0] DISP_ADDR,
    output logic [DATA_W-1:0]        DISP_DATA
);

    localparam int RAM_AW = $clog2(DEPTH);
    localparam int BE_W   = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DEPTH + REG_OFF_CTRL);
    localparam logic [ADDR_W-1:0] FILL_ADDR = ADDR_W'(DEPTH + REG_OFF_FILL);
    localparam logic [RAM_AW-1:0] LAST_IDX  = RAM_AW'(DEPTH - 1);

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    state_t              state;
    logic [RAM_AW-1:0]   clr_cnt;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   fill;

    logic                req;
    logic                hit_ram;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;
    logic                ctrl_wr;
    logic [DATA_W-1:0]   ctrl_word;

    logic                ram_en;
    logic [BE_W-1:0]     ram_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_q_a;

    logic                rd_vld_p1;
    logic                rd_sel_ram_p1;
    logic [DATA_W-1:0]   reg_rdata_p1;

    assign req     = AVL_CS && (AVL_READ || AVL_WRITE);
    assign hit_ram = (AVL_ADDR < CTRL_ADDR);
    // Only RAM-range traffic collides with the clear engine on port A.
    assign AVL_WAITREQUEST = busy && req && hit_ram;
    assign accept  = req && !AVL_WAITREQUEST;
    assign wr_acc  = accept && AVL_WRITE;
    assign rd_acc  = accept && !AVL_WRITE;
    assign ctrl_wr = wr_acc && (AVL_ADDR == CTRL_ADDR);

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_BUSY_BIT] = busy;
        ctrl_word[CTRL_DONE_BIT] = done;
    end

    // Port A owner: clear engine while busy, Avalon otherwise.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = AVL_ADDR[RAM_AW-1:0];
        ram_wdata = AVL_WRITEDATA;
        if (busy) begin
            ram_en    = 1'b1;
            ram_we    = '1;
            ram_addr  = clr_cnt;
            ram_wdata = fill;
        end else if (accept && hit_ram) begin
            ram_en = 1'b1;
            ram_we = AVL_WRITE ? AVL_BYTE_EN : '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fill    <= '0;
        end else begin
            // Takes effect on the next clear write, so words not yet
            // cleared pick up the new value.
            if (wr_acc && (AVL_ADDR == FILL_ADDR)) begin
                fill <= byte_merge(fill, AVL_WRITEDATA, AVL_BYTE_EN);
            end
            case (state)
                IDLE: begin
                    if (ctrl_wr && AVL_WRITEDATA[CTRL_START_BIT]) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                        done    <= 1'b0;
                    end else if (ctrl_wr && AVL_WRITEDATA[CTRL_ACK_BIT]) begin
                        done <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (ctrl_wr && AVL_WRITEDATA[CTRL_ACK_BIT]) begin
                        done <= 1'b0;
                    end
                    if (clr_cnt == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + RAM_AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage p1: read response ----
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_vld_p1     <= 1'b0;
            rd_sel_ram_p1 <= 1'b0;
            reg_rdata_p1  <= '0;
        end else begin
            rd_vld_p1 <= rd_acc;
            if (rd_acc) begin
                rd_sel_ram_p1 <= hit_ram;
                if (!hit_ram) begin
                    if (AVL_ADDR == CTRL_ADDR)      reg_rdata_p1 <= ctrl_word;
                    else if (AVL_ADDR == FILL_ADDR) reg_rdata_p1 <= fill;
                    else                            reg_rdata_p1 <= '0;
                end
            end
        end
    end

    // Both sources only change on an accepted read, so the mux holds.
    assign AVL_READDATA      = rd_sel_ram_p1 ? ram_q_a : reg_rdata_p1;
    assign AVL_READDATAVALID = rd_vld_p1;

    puzzle_ram_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (RESET),
        .en_a    (ram_en),
        .we_a    (ram_we),
        .addr_a  (ram_addr),
        .wdata_a (ram_wdata),
        .q_a     (ram_q_a),
        .addr_b  (DISP_ADDR),
        .q_b     (DISP_DATA)
    );

endmodule

// File: doc/puzzle_mem.md
PUZZLE_MEM -- requirements
Module: puzzle_mem

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, meaning data word width in bits (multiple of 8).
REQ-002 The module SHALL take parameter DEPTH, default 4096, meaning number of puzzle RAM words.
REQ-003 The module SHALL take parameter ADDR_W, default 13, meaning Avalon word-address width; DEPTH+2 <= 2**ADDR_W.
REQ-004 CLK  input  1  sole clock; all logic rising-edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 AVL_ADDR  input  ADDR_W  Avalon word address.
REQ-007 AVL_BYTE_EN  input  DATA_W/8  write byte enables.
REQ-008 AVL_CS  input  1  chip select; READ/WRITE ignored when low.
REQ-009 AVL_READ / AVL_WRITE  input  1 each  read / write request.
REQ-010 AVL_WRITEDATA  input  DATA_W  write data.
REQ-011 AVL_READDATA  output  DATA_W  registered read data.
REQ-012 AVL_READDATAVALID  output  1  read data qualifier.
REQ-013 AVL_WAITREQUEST  output  1  request stalled this cycle.
REQ-014 DISP_ADDR  input  $clog2(DEPTH)  display-side read address.
REQ-015 DISP_DATA  output  DATA_W  display-side read data.

Function
REQ-016 Address map: 0..DEPTH-1 = RAM words; DEPTH = CTRL; DEPTH+1 = FILL; higher addresses unmapped.
REQ-017 A request is accepted in a cycle where AVL_CS=1, (AVL_READ or AVL_WRITE)=1 and AVL_WAITREQUEST=0; READ and WRITE both high SHALL be treated as write only.
REQ-018 Accepted RAM write SHALL update only byte lanes with AVL_BYTE_EN=1, visible to reads the next cycle.
REQ-019 Accepted read SHALL drive AVL_READDATA and pulse AVL_READDATAVALID for exactly one cycle, one cycle after acceptance; back-to-back reads give back-to-back valids.
REQ-020 Unmapped reads SHALL return 0 with valid; unmapped writes SHALL be ignored.
REQ-021 AVL_READDATA SHALL hold its last value when AVL_READDATAVALID=0.
REQ-022 FILL register: R/W, byte-enabled, reset 0.
REQ-023 CTRL read SHALL return bit0=BUSY, bit1=DONE, other bits 0.
REQ-024 CTRL write with data bit0=1 in state IDLE SHALL enter CLEAR and clear DONE; bit1=1 SHALL clear DONE; start while in CLEAR SHALL be ignored.
REQ-025 FSM states IDLE, CLEAR; CLEAR writes FILL (all byte lanes) to word index 0,1,...,DEPTH-1, one per cycle, starting the cycle after the start write.
REQ-026 After writing word DEPTH-1 the FSM SHALL return to IDLE and set DONE; clear takes exactly DEPTH cycles; BUSY=1 exactly while in CLEAR.
REQ-027 In CLEAR, AVL_WAITREQUEST SHALL be 1 for any CS-qualified RAM-range read or write, 0 for CTRL/FILL/unmapped accesses; otherwise AVL_WAITREQUEST SHALL be 0.
REQ-028 FILL writes during CLEAR SHALL take effect for words not yet cleared.
REQ-029 DISP_DATA SHALL show RAM[DISP_ADDR] one cycle after DISP_ADDR is sampled, always, including during CLEAR.
REQ-030 Same-cycle port-A write and DISP read of the same word SHALL return the old data on DISP_DATA.

Reset
REQ-031 RESET low SHALL immediately force: state IDLE, clear counter 0, BUSY 0, DONE 0, FILL 0, AVL_READDATA 0, AVL_READDATAVALID 0, AVL_WAITREQUEST 0, DISP_DATA 0.
REQ-032 RESET mid-CLEAR SHALL abort the clear; partially cleared RAM contents are not restored; RAM array itself is not reset.

Structure
REQ-033 A shared package puzzle_pkg SHALL hold the state enum, CTRL bit indices (BUSY=0, DONE=1 read; START=0, ACK=1 write) and register-offset constants.
REQ-034 The storage SHALL be a sub-module puzzle_ram_dp: true dual-port inferred block RAM, port A read/write with byte enables, port B read-only, one-cycle registered outputs.

Verification
REQ-035 Write 0xDEADBEEF to addr 5 BYTE_EN=0xF, then BYTE_EN=0x2 data 0x00001100, read addr 5 -> READDATA 0xDEAD11EF with VALID one cycle after accept.
REQ-036 FILL=0x20202020, CTRL write 0x1 -> BUSY=1 for exactly DEPTH cycles, RAM read to addr 7 stalled by WAITREQUEST then returns 0x20202020, CTRL read afterwards = 0x2.
REQ-037 During CLEAR: CTRL start write ignored (total still DEPTH cycles); CTRL read completes without wait returning 0x1.
REQ-038 Read addr DEPTH+5 -> 0x0 with VALID; write there -> no RAM word changes.
REQ-039 Drop RESET at clear counter 100 -> BUSY=0, DONE=0 immediately; words 0..99 = FILL, word 100+ unchanged.
REQ-040 Port-A write 0x41 to addr 3 while DISP_ADDR=3 -> DISP_DATA old value next cycle, 0x41 the cycle after.
